// File: rtl/sim_ram_arbiter.sv
// Two-requester round-robin read arbiter in front of a single-port simulation RAM.
// One read is outstanding at a time; a stalled RAM is answered with a timeout error.
module sim_ram_arbiter #(
  parameter int WORD_SIZE = 1,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic [ADDR_SIZE-1:0]      req0_addr,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [ADDR_SIZE-1:0]      req1_addr,
  output logic                      req1_ready,
  output logic                      resp0_valid,
  output logic                      resp1_valid,
  output logic [WORD_SIZE*8-1:0]    resp_data,
  output logic                      resp_err,
  output logic                      ram_read_en,
  output logic [ADDR_SIZE-1:0]      ram_addr,
  input  logic [WORD_SIZE*8-1:0]    ram_read_data,
  input  logic                      ram_data_ready,
  output logic                      busy
);

  localparam int DW = WORD_SIZE * 8;
  localparam int AW = ADDR_SIZE;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg;
  logic            last_grant_reg;
  logic            owner_reg;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   resp_data_reg;
  logic            resp_err_reg;
  logic            resp0_reg;
  logic            resp1_reg;
  logic            read_en_reg;
  logic [AW-1:0]   ram_addr_reg;

  logic grant0;
  logic grant1;
  logic idle_open;

  // On a tie the requester that did not win last time is served.
  assign grant0    = req0_valid && (!req1_valid || last_grant_reg);
  assign grant1    = req1_valid && (!req0_valid || !last_grant_reg);
  assign idle_open = (state_reg == IDLE) && !rst;

  assign req0_ready  = idle_open && grant0;
  assign req1_ready  = idle_open && grant1;
  assign resp0_valid = resp0_reg;
  assign resp1_valid = resp1_reg;
  assign resp_data   = resp_data_reg;
  assign resp_err    = resp_err_reg;
  assign ram_read_en = read_en_reg;
  assign ram_addr    = ram_addr_reg;
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      cnt_reg        <= '0;
      resp_data_reg  <= '0;
      resp_err_reg   <= 1'b0;
      resp0_reg      <= 1'b0;
      resp1_reg      <= 1'b0;
      read_en_reg    <= 1'b0;
      ram_addr_reg   <= '0;
    end else begin
      resp0_reg   <= 1'b0;
      resp1_reg   <= 1'b0;
      read_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant0 || grant1) begin
            owner_reg      <= grant1;
            last_grant_reg <= grant1;
            ram_addr_reg   <= grant1 ? req1_addr : req0_addr;
            read_en_reg    <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (ram_data_ready) begin
            resp_data_reg <= ram_read_data;
            resp_err_reg  <= 1'b0;
            resp0_reg     <= !owner_reg;
            resp1_reg     <= owner_reg;
            state_reg     <= RESP;
          end else if (cnt_reg >= CNT_LAST) begin
            // This is the TIMEOUT-th silent WAIT cycle.
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b1;
            resp0_reg     <= !owner_reg;
            resp1_reg     <= owner_reg;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_ram_arbiter.sv
// Randomized scoreboard bench for sim_ram_arbiter: a cycle-level transaction model
// predicts handshakes and responses, a monitor compares every response pulse.
module tb_sim_ram_arbiter;

  localparam int TO     = 16;
  localparam int NCYC   = 2500;
  localparam int NEVER  = 999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [7:0]  resp_data;
  logic        resp_err;
  logic        ram_read_en;
  logic [31:0] ram_addr;
  logic [7:0]  ram_read_data = '0;
  logic        ram_data_ready = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  sim_ram_arbiter #(.WORD_SIZE(1), .ADDR_SIZE(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_err(resp_err),
    .ram_read_en(ram_read_en), .ram_addr(ram_addr),
    .ram_read_data(ram_read_data), .ram_data_ready(ram_data_ready),
    .busy(busy)
  );

  typedef struct {
    int         owner;
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_word(input logic [31:0] a);
    return (a[7:0] * 8'd13 + 8'h5B) ^ a[15:8];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // Monitor: pops the expected response whenever the DUT pulses a response.
  always @(negedge clk) begin
    exp_t e;
    if (resp0_valid || resp1_valid) begin
      if (q.size() == 0) begin
        chk("spurious_resp_queue_depth", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk("resp_one_hot", {63'd0, resp0_valid && resp1_valid}, 64'd0);
        chk("resp_owner", {63'd0, resp1_valid}, 64'(e.owner));
        chk("resp_data", 64'(resp_data), 64'(e.data));
        chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        $display("resp cyc=%0d owner=%0d data=%02h err=%0d", cyc, e.owner, resp_data, resp_err);
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("resp_missing", {62'd0, resp1_valid, resp0_valid}, 64'(1 << e.owner));
    end
  end

  // Stimulus plus transaction-level reference model.
  initial begin
    int          c, busy_until, read_cyc, ready_cyc, zero_chk, d, r;
    logic        last, v0, v1, g0, g1, spur, owner;
    logic [31:0] a0, a1, read_addr;
    exp_t        e;
    busy_until = 0; read_cyc = -1; ready_cyc = -1; zero_chk = -1;
    last = 1'b1; read_addr = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    chk("reset_read_en", {63'd0, ram_read_en}, 64'd0);
    chk("reset_ram_addr", 64'(ram_addr), 64'd0);
    chk("reset_resp", {55'd0, resp_err, resp_data}, 64'd0);
    chk("reset_resp_valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);

    for (int n = 0; n < NCYC; n++) begin
      if (n > 0) @(negedge clk);
      c = cyc;
      spur = 1'b0;
      if (n < 40) begin
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1; a0 = 32'h4; a1 = 32'h8;
      end else if (n >= NCYC - 60) begin
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; a0 = $urandom; a1 = $urandom;
      end else begin
        rst  = ($urandom_range(0, 79) == 0);
        v0   = ($urandom_range(0, 2) != 0);
        v1   = ($urandom_range(0, 2) != 0);
        a0   = $urandom;
        a1   = $urandom;
        spur = ($urandom_range(0, 3) == 0);
      end
      req0_valid = v0; req1_valid = v1; req0_addr = a0; req1_addr = a1;
      ram_data_ready = (c == ready_cyc) || (spur && (c >= busy_until || c == read_cyc));
      ram_read_data  = (c == ready_cyc) ? mem_word(read_addr) : 8'($urandom);

      #1;
      g0 = !rst && (c >= busy_until) && v0 && (!v1 || last);
      g1 = !rst && (c >= busy_until) && v1 && (!v0 || !last);
      chk("req0_ready", {63'd0, req0_ready}, {63'd0, g0});
      chk("req1_ready", {63'd0, req1_ready}, {63'd0, g1});
      chk("busy", {63'd0, busy}, {63'd0, c < busy_until});
      chk("ram_read_en", {63'd0, ram_read_en}, {63'd0, c == read_cyc});
      if (c == read_cyc) chk("ram_addr", 64'(ram_addr), 64'(read_addr));
      if (c == zero_chk) chk("post_reset_resp", {55'd0, resp_err, resp_data}, 64'd0);

      if (rst) begin
        // Outstanding work is dropped; a late RAM answer lands in IDLE.
        busy_until = c + 1;
        last = 1'b1;
        while (q.size() > 0 && q[q.size()-1].cyc > c) void'(q.pop_back());
        if (read_cyc > c) read_cyc = -1;
        if (ready_cyc > c) ready_cyc = c + 1;
        zero_chk = c + 1;
      end else if (g0 || g1) begin
        owner = g1;
        last = owner;
        read_addr = owner ? a1 : a0;
        read_cyc = c + 1;
        if (n < 40) d = 1;
        else begin
          r = $urandom_range(0, 9);
          d = (r < 5) ? 1 : (r == 5) ? 2 : (r == 6) ? $urandom_range(3, 6) :
              (r == 7) ? TO : (r == 8) ? TO + 1 : NEVER;
        end
        e.owner = int'(owner);
        if (d <= TO) begin
          ready_cyc = c + 1 + d;
          e.cyc  = c + 2 + d;
          e.data = mem_word(read_addr);
          e.err  = 1'b0;
        end else begin
          ready_cyc = (d == TO + 1) ? c + 1 + d : -1;
          e.cyc  = c + 2 + TO;
          e.data = 8'h00;
          e.err  = 1'b1;
        end
        busy_until = e.cyc + 1;
        q.push_back(e);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
